dot_product_fsm: RTL and testbench
==================================

Name: dot_product_fsm

Overview:
Single-clock consumer that sits directly downstream of two FIFOs: vector A and vector B, each DATA_WIDTH wide. On a start pulse it pops VEC_LEN element pairs and multiply-accumulates them, unsigned. It then presents the dot product on a valid/ready result interface. Each FIFO returns registered read data one cycle after rd_en is sampled with the FIFO non-empty, and this block's pipeline is built around that latency.

Parameters:
DATA_WIDTH, 8, width of each FIFO element.
VEC_LEN, 8, element pairs per dot product (≥1).
CNT_WIDTH, 4, counter width; must hold the value VEC_LEN.
ACC_WIDTH, 19, accumulator/result width; must be ≥ 2*DATA_WIDTH + ceil(log2(VEC_LEN)) so it cannot overflow.

Ports:
clk  in  1  single clock; all logic on its rising edge.
rstn  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse; begins one dot product when idle.
empty_a  in  1  FIFO A empty flag.
empty_b  in  1  FIFO B empty flag.
data_a  in  DATA_WIDTH  FIFO A read data, valid the cycle after rd_en_a.
data_b  in  DATA_WIDTH  FIFO B read data, valid the cycle after rd_en_b.
rd_en_a  out  1  pop FIFO A.
rd_en_b  out  1  pop FIFO B.
result  out  ACC_WIDTH  dot product.
result_valid  out  1  result available.
result_ready  in  1  downstream accepts result.
busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: single clock clk. Reset rstn is asynchronous and active-low; it clears all state immediately, regardless of the clock.
- Reset values: state=IDLE; issued=0; consumed=0; acc=0; fire_d=0; result=0; result_valid=0; busy=0. rd_en_a and rd_en_b go low immediately on reset.
- IDLE:
  - start=1 → RUN.
  - In the same edge, clear acc, issued and consumed.
  - busy rises the next cycle.
- RUN:
  - Pop enable is combinational: pop = !empty_a && !empty_b && (issued < VEC_LEN).
  - rd_en_a = rd_en_b = pop. Both FIFOs are always popped together, never one alone.
  - On pop: issued++.
  - fire_d <= pop, registered.
  - When fire_d=1: acc <= acc + data_a*data_b. The product is zero-extended to ACC_WIDTH. consumed++.
  - When consumed reaches VEC_LEN (including the final accumulate edge): result <= final acc, result_valid <= 1, → DONE.
- Throughput and latency:
  - One pair per cycle while both FIFOs are non-empty.
  - With no bubbles, result_valid asserts VEC_LEN+2 cycles after the start edge.
- Bubbles: if either FIFO is empty, pop=0 that cycle and no read is issued. Accumulation resumes when both are non-empty. The result is independent of bubble pattern.
- DONE:
  - result and result_valid hold stable while result_ready=0.
  - On result_valid && result_ready: result_valid <= 0, → IDLE.
  - result keeps its last value after the handshake.
- start while busy (RUN or DONE): ignored, with no effect on counters or acc.
- After issued=VEC_LEN, no further rd_en is driven even if the FIFOs still hold data. Excess data remains for the next run.
- Reset mid-operation: returns to IDLE immediately, and any in-flight product is discarded. The FIFOs are reset separately by the system.
- The accumulator never wraps under the ACC_WIDTH rule; no overflow flag is provided.

Decomposition:
- Shared package dot_product_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - default DATA_WIDTH, VEC_LEN, CNT_WIDTH and ACC_WIDTH constants.
- One sub-module, dot_product_mac:
  - inputs: clk, rstn, clr, en, a, b; output: acc.
  - Registered multiply-accumulate.
  - The FSM drives clr from IDLE+start and en from fire_d.
- Counters, pop logic and the result register stay in the top module.

Test Plan:
- Reset → hold rstn=0 asynchronously mid-cycle: rd_en_a/b, result_valid and busy go 0 immediately; result=0.
- Basic run → A=1..8 and B=2,2,...,2 preloaded, start pulse, result_ready=1:
  - rd_en high 8 consecutive cycles;
  - result=72 with result_valid on cycle 10 after start;
  - busy falls one cycle after the handshake.
- Max values → A=B=255 ×8: result=520200 with no overflow.
- Bubbles → empty_b toggles every other cycle, A=B=1..8:
  - rd_en never high while either FIFO is empty;
  - exactly 8 pops;
  - result=204.
- Backpressure and start while busy → result_ready=0 for 5 cycles, with start pulsed during RUN and during DONE:
  - result_valid and result stay stable;
  - the extra starts are ignored;
  - one handshake then IDLE.
- Reset mid-run → assert rstn after 3 pops, then rerun with fresh data A=1..8, B=1: result=36 with no contamination from the aborted run.

Source files
------------

// File: rtl/dot_product_pkg.sv
// rtl/dot_product_pkg.sv - shared state encoding and default sizing for the dot-product engine
package dot_product_pkg;

  localparam int DP_DATA_WIDTH = 8;
  localparam int DP_VEC_LEN    = 8;
  localparam int DP_CNT_WIDTH  = 4;
  localparam int DP_ACC_WIDTH  = 19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dot_product_mac.sv
// rtl/dot_product_mac.sv - registered unsigned multiply-accumulate with synchronous clear
module dot_product_mac
  import dot_product_pkg::*;
#(
  parameter int DATA_WIDTH = DP_DATA_WIDTH,
  parameter int ACC_WIDTH  = DP_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc
);

  logic [2*DATA_WIDTH-1:0] prod;

  assign prod = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};

  // clear wins over accumulate so a new run never inherits a stale product
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + {{(ACC_WIDTH-2*DATA_WIDTH){1'b0}}, prod};
    end
  end

endmodule

// File: rtl/dot_product_fsm.sv
// rtl/dot_product_fsm.sv - pops paired FIFO elements, accumulates their products, hands off the sum
module dot_product_fsm
  import dot_product_pkg::*;
#(
  parameter int DATA_WIDTH = DP_DATA_WIDTH,
  parameter int VEC_LEN    = DP_VEC_LEN,
  parameter int CNT_WIDTH  = DP_CNT_WIDTH,
  parameter int ACC_WIDTH  = DP_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  empty_a,
  input  logic                  empty_b,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  rd_en_a,
  output logic                  rd_en_b,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy
);

  localparam logic [CNT_WIDTH-1:0] LEN = CNT_WIDTH'(VEC_LEN);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] issued, consumed;
  logic                 fire_d, pop, clr;
  logic [ACC_WIDTH-1:0] acc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          clr       = 1'b1;
        end
      end
      RUN: begin
        pop = !empty_a && !empty_b && (issued < LEN);
        if (consumed == LEN) state_nxt = DONE;
      end
      DONE: begin
        if (result_valid && result_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_en_a = pop;
  assign rd_en_b = pop;
  assign busy    = (state != IDLE);

  // fire_d marks the cycle in which the FIFO read data for a pop is on data_a/data_b
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      issued       <= '0;
      consumed     <= '0;
      fire_d       <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      fire_d <= pop;
      case (state)
        IDLE: begin
          if (start) begin
            issued   <= '0;
            consumed <= '0;
          end
        end
        RUN: begin
          if (pop)    issued   <= issued + 1'b1;
          if (fire_d) consumed <= consumed + 1'b1;
          if (consumed == LEN) begin
            result       <= acc;
            result_valid <= 1'b1;
          end
        end
        DONE: begin
          if (result_ready) result_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  dot_product_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk (clk),
    .rstn(rstn),
    .clr (clr),
    .en  (fire_d),
    .a   (data_a),
    .b   (data_b),
    .acc (acc)
  );

endmodule

// File: tb/tb_dot_product_fsm.sv
// tb/tb_dot_product_fsm.sv - directed and randomized bench with a FIFO model and arithmetic reference
module tb_dot_product_fsm;
  import dot_product_pkg::*;

  localparam int DW = DP_DATA_WIDTH;
  localparam int VL = DP_VEC_LEN;
  localparam int CW = DP_CNT_WIDTH;
  localparam int AW = DP_ACC_WIDTH;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          start = 1'b0;
  logic          result_ready = 1'b0;
  logic          empty_a = 1'b1;
  logic          empty_b = 1'b1;
  logic [DW-1:0] data_a = '0;
  logic [DW-1:0] data_b = '0;
  logic          rd_en_a, rd_en_b, result_valid, busy;
  logic [AW-1:0] result;

  int qa[$];
  int qb[$];
  int va[VL];
  int vb[VL];
  bit bub_a = 1'b0, bub_b = 1'b0, tog_b = 1'b0, rnd_bub = 1'b0;
  int exp_res;
  int checks = 0, failures = 0;
  int pops = 0, viol = 0, consec = 0, max_consec = 0;
  int lat;
  logic [AW-1:0] r0;

  dot_product_fsm #(
    .DATA_WIDTH(DW), .VEC_LEN(VL), .CNT_WIDTH(CW), .ACC_WIDTH(AW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .empty_a(empty_a), .empty_b(empty_b),
    .data_a(data_a), .data_b(data_b),
    .rd_en_a(rd_en_a), .rd_en_b(rd_en_b),
    .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // FIFO flags move away from the sampling edge
  always @(negedge clk) begin
    if (tog_b) bub_b = ~bub_b;
    if (rnd_bub) begin
      bub_a = ($urandom_range(0, 2) == 0);
      bub_b = ($urandom_range(0, 2) == 0);
    end
    empty_a = (qa.size() == 0) || bub_a;
    empty_b = (qb.size() == 0) || bub_b;
  end

  // FIFO read port: registered data one cycle after a sampled rd_en
  always @(posedge clk) begin
    if (rd_en_a) begin
      pops = pops + 1;
      consec = consec + 1;
      if (consec > max_consec) max_consec = consec;
    end else begin
      consec = 0;
    end
    if ((rd_en_a !== rd_en_b) || ((rd_en_a || rd_en_b) && (empty_a || empty_b))) viol = viol + 1;
    if (rd_en_a && qa.size() > 0) data_a <= DW'(qa.pop_front());
    if (rd_en_b && qb.size() > 0) data_b <= DW'(qb.pop_front());
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input int extra);
    exp_res = 0;
    for (int i = 0; i < VL; i++) begin
      qa.push_back(va[i]);
      qb.push_back(vb[i]);
      exp_res = exp_res + va[i] * vb[i];
    end
    for (int i = 0; i < extra; i++) begin
      qa.push_back(int'($urandom_range(0, 255)));
      qb.push_back(int'($urandom_range(0, 255)));
    end
    @(negedge clk);
  endtask

  task automatic run(input int start_again_at);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!result_valid && lat < 400) begin
      start = (lat == start_again_at);
      @(negedge clk);
      lat = lat + 1;
    end
    start = 1'b0;
    chk("valid_seen", 32'(result_valid), 32'd1);
  endtask

  initial begin
    #2 rstn = 1'b0;
    #1;
    chk("rst_rd_en_a", 32'(rd_en_a), 32'd0);
    chk("rst_rd_en_b", 32'(rd_en_b), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    result_ready = 1'b1;

    // basic: A=1..8, B=2
    for (int i = 0; i < VL; i++) begin va[i] = i + 1; vb[i] = 2; end
    load(0);
    pops = 0; max_consec = 0;
    run(-1);
    chk("basic_latency", 32'(lat), 32'(VL + 2));
    chk("basic_result", 32'(result), 32'd72);
    chk("basic_busy_at_valid", 32'(busy), 32'd1);
    chk("basic_consec_pops", 32'(max_consec), 32'(VL));
    chk("basic_pops", 32'(pops), 32'(VL));
    @(negedge clk);
    chk("basic_busy_after_hs", 32'(busy), 32'd0);
    chk("basic_valid_after_hs", 32'(result_valid), 32'd0);
    chk("basic_result_kept", 32'(result), 32'd72);

    // max values with surplus data left in the FIFOs
    for (int i = 0; i < VL; i++) begin va[i] = 255; vb[i] = 255; end
    load(2);
    pops = 0;
    run(-1);
    chk("max_result", 32'(result), 32'(exp_res));
    chk("max_result_const", 32'(result), 32'd520200);
    @(negedge clk);
    @(negedge clk);
    chk("max_pops", 32'(pops), 32'(VL));
    chk("max_leftover", 32'(qa.size()), 32'd2);
    qa.delete(); qb.delete();

    // bubbles on B every other cycle
    for (int i = 0; i < VL; i++) begin va[i] = i + 1; vb[i] = i + 1; end
    load(0);
    pops = 0; viol = 0; tog_b = 1'b1;
    run(-1);
    chk("bubble_result", 32'(result), 32'd204);
    @(negedge clk);
    tog_b = 1'b0; bub_b = 1'b0;
    chk("bubble_pops", 32'(pops), 32'(VL));
    chk("bubble_violations", 32'(viol), 32'd0);

    // backpressure, start pulsed in RUN and in DONE
    result_ready = 1'b0;
    for (int i = 0; i < VL; i++) begin
      va[i] = int'($urandom_range(0, 255));
      vb[i] = int'($urandom_range(0, 255));
    end
    load(VL);
    pops = 0;
    run(3);
    chk("bp_result", 32'(result), 32'(exp_res));
    r0 = result;
    for (int k = 0; k < 5; k++) begin
      start = (k == 1);
      @(negedge clk);
      chk("bp_valid_hold", 32'(result_valid), 32'd1);
      chk("bp_result_hold", 32'(result), 32'(r0));
    end
    start = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_after_hs", 32'(result_valid), 32'd0);
    chk("bp_busy_after_hs", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("bp_pops", 32'(pops), 32'(VL));
    chk("bp_idle", 32'(busy), 32'd0);
    qa.delete(); qb.delete();

    // asynchronous reset after three pops, then a clean rerun
    for (int i = 0; i < VL; i++) begin
      va[i] = int'($urandom_range(1, 255));
      vb[i] = int'($urandom_range(1, 255));
    end
    load(0);
    pops = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 50 && pops < 3; n++) @(negedge clk);
    chk("abort_pops_reached", 32'(pops), 32'd3);
    #2 rstn = 1'b0;
    #1;
    chk("abort_rd_en", 32'(rd_en_a), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(result_valid), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    qa.delete(); qb.delete();
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < VL; i++) begin va[i] = i + 1; vb[i] = 1; end
    load(0);
    run(-1);
    chk("rerun_result", 32'(result), 32'd36);
    chk("rerun_latency", 32'(lat), 32'(VL + 2));
    @(negedge clk);

    // randomized data with random bubbles on both FIFOs
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < VL; i++) begin
        va[i] = int'($urandom_range(0, 255));
        vb[i] = int'($urandom_range(0, 255));
      end
      load(0);
      pops = 0; viol = 0; rnd_bub = 1'b1;
      run(-1);
      chk("rand_result", 32'(result), 32'(exp_res));
      rnd_bub = 1'b0; bub_a = 1'b0; bub_b = 1'b0;
      @(negedge clk);
      chk("rand_pops", 32'(pops), 32'(VL));
      chk("rand_violations", 32'(viol), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
